jvm_useq_ctrl: RTL and testbench
================================

// Module: jvm_useq_ctrl
// PURPOSE
//  Microcode sequencer for the bytecode execution path. Accepts one JVM opcode at a time
//  and sequences the 512x7 start/next-address ROM. Emits one micro-op address per step
//  until the micro-op decoder flags the last step.
//  Sits between the bytecode fetch stage and the micro-op decoder.
//  Unsupported opcodes and broken micro-op chains raise a trap to the JIT/host.
// PARAMETERS
//  MAX_STEPS  32  max micro-ops per opcode; exceeding this raises a trap
//  CNT_W      16  width of the retired-opcode counter
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  flush        in   1      synchronous abort (branch/exception), highest priority
//  op_valid     in   1      fetch offers an opcode
//  op_code      in   8      JVM opcode
//  op_ready     out  1      sequencer can accept an opcode
//  rom_addr     out  9      to address ROM; combinational ROM, data valid same cycle
//  rom_data     in   7      from address ROM; 0 = no entry, 7'h7F = out of range
//  uop_valid    out  1      micro-op address valid
//  uop_addr     out  7      current micro-op address
//  uop_ready    in   1      decoder accepts micro-op
//  uop_last     in   1      decoder: current micro-op ends the opcode (qualified by handshake)
//  trap_valid   out  1      trap pending
//  trap_cause   out  2      01 unsupported op, 10 chain break, 11 step overflow
//  trap_op      out  8      opcode that trapped
//  trap_ack     in   1      host acknowledges trap
//  busy         out  1      state != IDLE
//  retired_cnt  out  CNT_W  opcodes completed; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=IDLE, uop_addr=0, step=0, trap_cause=0, trap_op=0, retired_cnt=0.
//  Reset: uop_valid=0, trap_valid=0, busy=0.
//  op_ready = (state==IDLE) & ~flush.
//  rom_addr: {1'b0,op_code} in IDLE; {1'b0,op_lat} in LOOKUP; {2'b10,uop_addr} in EXEC.
//  IDLE: op_valid&op_ready -> latch op_lat=op_code, step=0 -> LOOKUP.
//  LOOKUP: one cycle.
//   - rom_data==0 or 7'h7F -> TRAP, cause 01.
//   - else uop_addr<=rom_data -> EXEC.
//   - Opcode-accept to first uop_valid latency = 2 cycles.
//  EXEC: uop_valid=1; uop_addr held stable until uop_valid&uop_ready.
//   On handshake:
//   - uop_last=1 -> retired_cnt+1 -> IDLE.
//   - step==MAX_STEPS-1 -> TRAP, cause 11.
//   - rom_data==0 or 7'h7F -> TRAP, cause 10.
//   - else uop_addr<=rom_data, step+1, stay in EXEC (back-to-back micro-ops, 1 per cycle).
//  TRAP: trap_valid=1; cause and op held stable. trap_ack -> IDLE, trap_valid drops next cycle.
//  flush: from any state -> IDLE next cycle.
//   - uop_valid and trap_valid low next cycle; pending trap is discarded; retired_cnt unchanged.
//   - flush with a same-cycle op handshake: the op is not accepted (op_ready low).
//  uop_last is ignored outside the handshake. No self-loop detection beyond MAX_STEPS.
//  Reset asserted mid-operation: immediate return to reset values; no partial retire.
// STRUCTURE
//  Shared package jvm_useq_pkg:
//   - state enum {IDLE, LOOKUP, EXEC, TRAP}
//   - TRAP_UNSUP/TRAP_CHAIN/TRAP_OVF codes
//   - UADDR_W=7, ROM_AW=9, UADDR_NONE=7'd0, UADDR_BAD=7'h7F.
//  No sub-module: FSM, step counter and retire counter are local.
//  Address ROM stays outside, wired at the core top level, so the bench can drive a ROM model.
// TESTING
//  1 ROM {0,0x0B}=11, {1,0,11}=10, decoder uop_last on 2nd step
//    -> uop_addr 11 then 10 on consecutive cycles, retired_cnt=1, op_ready back high.
//  2 op 0x10, ROM entry 0 -> trap_valid, cause 01, trap_op 0x10, no uop_valid;
//    held until trap_ack, then IDLE.
//  3 uop_ready low 5 cycles mid-chain -> uop_addr stable, no step advance, rom_addr={2'b10,uop_addr}.
//  4 chain 3->5->3 loop, uop_last never set -> trap cause 11 after 32 handshakes.
//  5 flush while EXEC with uop_valid high -> IDLE next cycle, uop_valid 0, retired_cnt unchanged;
//    flush in TRAP clears trap_valid.
//  6 rst_n low mid-EXEC -> all outputs at reset values asynchronously;
//    retired_cnt from 0xFFFF +1 -> 0x0000.

Source files
------------

// File: rtl/jvm_useq_pkg.sv
// Shared types and constants for the JVM microcode sequencer.
package jvm_useq_pkg;

    localparam int OP_W    = 8;
    localparam int UADDR_W = 7;
    localparam int ROM_AW  = 9;

    localparam logic [UADDR_W-1:0] UADDR_NONE = 7'd0;
    localparam logic [UADDR_W-1:0] UADDR_BAD  = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        EXEC   = 2'd2,
        TRAP   = 2'd3
    } useq_state_e;

    typedef enum logic [1:0] {
        TRAP_NONE  = 2'b00,
        TRAP_UNSUP = 2'b01,
        TRAP_CHAIN = 2'b10,
        TRAP_OVF   = 2'b11
    } trap_cause_e;

    // A ROM word of 0 or all-ones means "no usable micro-op address".
    function automatic logic uaddr_invalid(input logic [UADDR_W-1:0] a);
        return (a == UADDR_NONE) || (a == UADDR_BAD);
    endfunction

endpackage

// File: rtl/jvm_useq_ctrl_if.sv
// Bundle of fetch, address-ROM, decoder and trap signals around the sequencer.
interface jvm_useq_ctrl_if
    import jvm_useq_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic                flush;
    logic                op_valid;
    logic [OP_W-1:0]     op_code;
    logic                op_ready;
    logic [ROM_AW-1:0]   rom_addr;
    logic [UADDR_W-1:0]  rom_data;
    logic                uop_valid;
    logic [UADDR_W-1:0]  uop_addr;
    logic                uop_ready;
    logic                uop_last;
    logic                trap_valid;
    logic [1:0]          trap_cause;
    logic [OP_W-1:0]     trap_op;
    logic                trap_ack;
    logic                busy;
    logic [CNT_W-1:0]    retired_cnt;

    // Sequencer side
    modport master (
        input  flush, op_valid, op_code, rom_data, uop_ready, uop_last, trap_ack,
        output op_ready, rom_addr, uop_valid, uop_addr, trap_valid, trap_cause,
               trap_op, busy, retired_cnt
    );

    // Environment side (fetch, ROM, decoder, host)
    modport slave (
        output flush, op_valid, op_code, rom_data, uop_ready, uop_last, trap_ack,
        input  op_ready, rom_addr, uop_valid, uop_addr, trap_valid, trap_cause,
               trap_op, busy, retired_cnt
    );

endinterface

// File: rtl/jvm_useq_ctrl.sv
// Microcode sequencer: takes one JVM opcode, walks the start/next-address ROM
// and emits one micro-op address per decoder handshake until the decoder flags
// the last step. Bad entries and over-long chains raise a trap to the host.
module jvm_useq_ctrl
    import jvm_useq_pkg::*;
#(
    parameter int MAX_STEPS = 32,
    parameter int CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    jvm_useq_ctrl_if.master bus
);

    localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

    useq_state_e          r_state;
    useq_state_e          w_state_nxt;
    logic [OP_W-1:0]      r_op_lat;
    logic [UADDR_W-1:0]   r_uop_addr;
    logic [STEP_W-1:0]    r_step;
    logic [1:0]           r_trap_cause;
    logic [OP_W-1:0]      r_trap_op;
    logic [CNT_W-1:0]     r_retired;

    logic                 w_accept;
    logic                 w_load_uaddr;
    logic                 w_step_inc;
    logic                 w_retire;
    logic                 w_set_trap;
    logic [1:0]           w_cause_nxt;
    logic [ROM_AW-1:0]    w_rom_addr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and datapath strobes; flush overrides every transition
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_load_uaddr = 1'b0;
        w_step_inc   = 1'b0;
        w_retire     = 1'b0;
        w_set_trap   = 1'b0;
        w_cause_nxt  = TRAP_NONE;
        if (bus.flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.op_valid) begin
                        w_accept    = 1'b1;
                        w_state_nxt = LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (uaddr_invalid(bus.rom_data)) begin
                        w_set_trap  = 1'b1;
                        w_cause_nxt = TRAP_UNSUP;
                        w_state_nxt = TRAP;
                    end else begin
                        w_load_uaddr = 1'b1;
                        w_state_nxt  = EXEC;
                    end
                end
                EXEC: begin
                    // uop_last only matters on an accepted micro-op
                    if (bus.uop_ready) begin
                        if (bus.uop_last) begin
                            w_retire    = 1'b1;
                            w_state_nxt = IDLE;
                        end else if (r_step == STEP_LAST) begin
                            w_set_trap  = 1'b1;
                            w_cause_nxt = TRAP_OVF;
                            w_state_nxt = TRAP;
                        end else if (uaddr_invalid(bus.rom_data)) begin
                            w_set_trap  = 1'b1;
                            w_cause_nxt = TRAP_CHAIN;
                            w_state_nxt = TRAP;
                        end else begin
                            w_load_uaddr = 1'b1;
                            w_step_inc   = 1'b1;
                        end
                    end
                end
                TRAP: begin
                    if (bus.trap_ack) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Opcode latch, micro-op address, step count, trap record and retire count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_lat     <= '0;
            r_uop_addr   <= UADDR_NONE;
            r_step       <= '0;
            r_trap_cause <= TRAP_NONE;
            r_trap_op    <= '0;
            r_retired    <= '0;
        end else begin
            if (w_accept) begin
                r_op_lat <= bus.op_code;
                r_step   <= '0;
            end
            if (w_load_uaddr) r_uop_addr <= bus.rom_data;
            if (w_step_inc)   r_step     <= r_step + STEP_W'(1);
            if (w_set_trap) begin
                r_trap_cause <= w_cause_nxt;
                r_trap_op    <= r_op_lat;
            end
            if (w_retire)     r_retired  <= r_retired + CNT_W'(1);
        end
    end

    // ROM address: start table while fetching/looking up, next table while executing
    always_comb begin
        w_rom_addr = {1'b0, r_op_lat};
        case (r_state)
            IDLE:    w_rom_addr = {1'b0, bus.op_code};
            LOOKUP:  w_rom_addr = {1'b0, r_op_lat};
            EXEC:    w_rom_addr = {2'b10, r_uop_addr};
            default: w_rom_addr = {1'b0, r_op_lat};
        endcase
    end

    assign bus.rom_addr    = w_rom_addr;
    assign bus.op_ready    = (r_state == IDLE) & ~bus.flush;
    assign bus.uop_valid   = (r_state == EXEC);
    assign bus.uop_addr    = r_uop_addr;
    assign bus.trap_valid  = (r_state == TRAP);
    assign bus.trap_cause  = r_trap_cause;
    assign bus.trap_op     = r_trap_op;
    assign bus.busy        = (r_state != IDLE);
    assign bus.retired_cnt = r_retired;

endmodule

// File: tb/tb_jvm_useq_ctrl.sv
// Bench for jvm_useq_ctrl: directed scenarios plus randomized opcodes checked
// against a ROM-walking reference model.
module tb_jvm_useq_ctrl;

    localparam int MAXS = 32;
    localparam int CW   = 8;   // narrow counter so the wrap is reachable quickly

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jvm_useq_ctrl_if #(.CNT_W(CW)) bus ();

    jvm_useq_ctrl #(.MAX_STEPS(MAXS), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Address ROM model: [0..255] start table, [256..383] next table
    logic [6:0] rom [512];
    assign bus.rom_data = rom[bus.rom_addr];

    int n_tests = 0;
    int n_fail  = 0;
    int r_model = 0;          // expected retired count, modulo 2^CW

    // Reference result of one opcode
    logic [6:0] exp_q[$];
    int         exp_trap;
    int         exp_cause;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit bad(input logic [6:0] a);
        return (a == 7'd0) || (a == 7'h7F);
    endfunction

    // Walk the ROM as the spec describes: list the addresses the decoder will see,
    // given the decoder ends the opcode on handshake number last_k (0-based).
    task automatic model(input logic [7:0] op, input int last_k);
        logic [6:0] a;
        exp_q.delete();
        exp_trap  = 0;
        exp_cause = 0;
        a = rom[{1'b0, op}];
        if (bad(a)) begin exp_trap = 1; exp_cause = 1; return; end
        for (int k = 0; k < MAXS; k++) begin
            exp_q.push_back(a);
            if (k == last_k)   return;
            if (k == MAXS - 1) begin exp_trap = 1; exp_cause = 3; return; end
            a = rom[256 + int'(a)];
            if (bad(a)) begin exp_trap = 1; exp_cause = 2; return; end
        end
    endtask

    task automatic issue_op(input logic [7:0] op);
        int n = 0;
        while (!bus.op_ready && n < 50) begin tick(); n++; end
        check("op_ready_wait", {31'd0, bus.op_ready}, 32'd1);
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        tick();
        bus.op_valid = 1'b0;
        check("accepted_busy", {31'd0, bus.busy}, 32'd1);
    endtask

    // Randomized opcode run with decoder stalls, compared to the model
    task automatic run_op(input logic [7:0] op, input int last_k, input int stall_pct);
        int  k = 0, cyc = 0;
        bit  done = 0, got_trap = 0, rdy;
        logic [1:0] g_cause = 0;
        logic [7:0] g_op = 0;
        model(op, last_k);
        issue_op(op);
        while (!done && cyc < 400) begin
            if (bus.trap_valid) begin
                got_trap = 1; g_cause = bus.trap_cause; g_op = bus.trap_op;
                bus.trap_ack = 1'b1;
                tick();
                bus.trap_ack = 1'b0;
                done = 1;
            end else if (bus.uop_valid) begin
                rdy = ($urandom_range(99) >= stall_pct);
                bus.uop_ready = rdy;
                bus.uop_last  = rdy ? (k == last_k) : 1'($urandom_range(1));
                if (rdy) begin
                    check("rnd_uaddr", {25'd0, bus.uop_addr},
                          (k < exp_q.size()) ? {25'd0, exp_q[k]} : 32'hFFFF_FFFF);
                    k++;
                end
                tick();
                bus.uop_ready = 1'b0;
                bus.uop_last  = 1'b0;
            end else if (!bus.busy) begin
                done = 1;
            end else begin
                tick();
            end
            cyc++;
        end
        check("rnd_done", {31'd0, done}, 32'd1);
        check("rnd_handshakes", k, exp_q.size());
        check("rnd_trap", {31'd0, got_trap}, exp_trap);
        if (exp_trap != 0) begin
            check("rnd_cause", {30'd0, g_cause}, exp_cause);
            check("rnd_trap_op", {24'd0, g_op}, {24'd0, op});
        end else begin
            r_model = (r_model + 1) % (1 << CW);
        end
        check("rnd_retired", bus.retired_cnt, r_model);
    endtask

    initial begin
        int hs;
        int n;
        bus.flush = 0; bus.op_valid = 0; bus.op_code = 0;
        bus.uop_ready = 0; bus.uop_last = 0; bus.trap_ack = 0;
        for (int i = 0; i < 512; i++) rom[i] = 7'd0;

        // Reset values
        #12;
        check("rst_op_ready", {31'd0, bus.op_ready}, 1);
        check("rst_uop_valid", {31'd0, bus.uop_valid}, 0);
        check("rst_trap_valid", {31'd0, bus.trap_valid}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_uop_addr", {25'd0, bus.uop_addr}, 0);
        check("rst_cause", {30'd0, bus.trap_cause}, 0);
        check("rst_trap_op", {24'd0, bus.trap_op}, 0);
        check("rst_retired", bus.retired_cnt, 0);
        rst_n = 1'b1;
        tick();

        // 1: two-step opcode, 2-cycle latency, back-to-back micro-ops
        rom[9'h00B] = 7'd11; rom[9'h10B] = 7'd10;
        issue_op(8'h0B);
        check("t1_lookup_noval", {31'd0, bus.uop_valid}, 0);
        check("t1_lookup_addr", {23'd0, bus.rom_addr}, 32'h00B);
        tick();
        check("t1_val", {31'd0, bus.uop_valid}, 1);
        check("t1_addr0", {25'd0, bus.uop_addr}, 11);
        check("t1_rom_addr", {23'd0, bus.rom_addr}, 32'h10B);
        bus.uop_ready = 1; bus.uop_last = 0;
        tick();
        check("t1_addr1", {25'd0, bus.uop_addr}, 10);
        check("t1_val1", {31'd0, bus.uop_valid}, 1);
        bus.uop_last = 1;
        tick();
        bus.uop_ready = 0; bus.uop_last = 0;
        r_model = 1;
        check("t1_retired", bus.retired_cnt, r_model);
        check("t1_op_ready", {31'd0, bus.op_ready}, 1);
        check("t1_noval", {31'd0, bus.uop_valid}, 0);

        // 2: unsupported opcode traps and holds until ack
        rom[9'h010] = 7'd0;
        issue_op(8'h10);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t2_trap_valid", {31'd0, bus.trap_valid}, 1);
            check("t2_cause", {30'd0, bus.trap_cause}, 1);
            check("t2_op", {24'd0, bus.trap_op}, 32'h10);
            check("t2_no_uop", {31'd0, bus.uop_valid}, 0);
            tick();
        end
        bus.trap_ack = 1;
        tick();
        bus.trap_ack = 0;
        check("t2_cleared", {31'd0, bus.trap_valid}, 0);
        check("t2_idle", {31'd0, bus.busy}, 0);

        // 3: decoder stall holds address and step
        rom[9'h020] = 7'd5; rom[9'h105] = 7'd6; rom[9'h106] = 7'd7;
        issue_op(8'h20);
        tick();
        bus.uop_ready = 1;
        tick();
        bus.uop_ready = 0;
        for (int i = 0; i < 5; i++) begin
            bus.uop_last = 1'($urandom_range(1));
            tick();
            check("t3_hold_addr", {25'd0, bus.uop_addr}, 6);
            check("t3_hold_rom", {23'd0, bus.rom_addr}, 32'h106);
        end
        bus.uop_ready = 1; bus.uop_last = 0;
        tick();
        check("t3_addr2", {25'd0, bus.uop_addr}, 7);
        bus.uop_last = 1;
        tick();
        bus.uop_ready = 0; bus.uop_last = 0;
        r_model++;
        check("t3_retired", bus.retired_cnt, r_model);

        // 4: 3->5->3 loop overflows after MAX_STEPS handshakes
        rom[9'h030] = 7'd3; rom[9'h103] = 7'd5; rom[9'h105] = 7'd3;
        issue_op(8'h30);
        bus.uop_ready = 1;
        hs = 0; n = 0;
        while (!bus.trap_valid && n < 100) begin
            if (bus.uop_valid) hs++;
            tick();
            n++;
        end
        bus.uop_ready = 0;
        check("t4_handshakes", hs, MAXS);
        check("t4_cause", {30'd0, bus.trap_cause}, 3);
        check("t4_op", {24'd0, bus.trap_op}, 32'h30);
        bus.trap_ack = 1; tick(); bus.trap_ack = 0;
        rom[9'h105] = 7'd6;

        // 5: flush in EXEC (with a same-cycle last handshake), in IDLE, in TRAP
        issue_op(8'h0B);
        tick();
        check("t5_exec", {31'd0, bus.uop_valid}, 1);
        bus.flush = 1; bus.uop_ready = 1; bus.uop_last = 1;
        tick();
        bus.flush = 0; bus.uop_ready = 0; bus.uop_last = 0;
        check("t5_noval", {31'd0, bus.uop_valid}, 0);
        check("t5_idle", {31'd0, bus.busy}, 0);
        check("t5_retired", bus.retired_cnt, r_model);
        bus.flush = 1; bus.op_valid = 1; bus.op_code = 8'h0B;
        #1;
        check("t5_op_ready_low", {31'd0, bus.op_ready}, 0);
        tick();
        bus.flush = 0; bus.op_valid = 0;
        check("t5_not_accepted", {31'd0, bus.busy}, 0);
        issue_op(8'h10);
        tick();
        check("t5_trap", {31'd0, bus.trap_valid}, 1);
        bus.flush = 1;
        tick();
        bus.flush = 0;
        check("t5_trap_flushed", {31'd0, bus.trap_valid}, 0);
        check("t5_trap_idle", {31'd0, bus.busy}, 0);

        // Randomized phase against the model
        for (int i = 0; i < 256; i++) begin
            n = $urandom_range(99);
            rom[i] = (n < 20) ? 7'd0 : (n < 25) ? 7'h7F : 7'($urandom_range(126, 1));
        end
        for (int i = 256; i < 384; i++) begin
            n = $urandom_range(99);
            rom[i] = (n < 6) ? 7'd0 : (n < 9) ? 7'h7F : 7'($urandom_range(126, 1));
        end
        for (int i = 0; i < 60; i++)
            run_op(8'($urandom_range(255)), int'($urandom_range(40)), int'($urandom_range(50)));

        // 6: reset mid-EXEC is immediate, then counter wraps
        rom[9'h00B] = 7'd11; rom[9'h10B] = 7'd10;
        issue_op(8'h0B);
        tick();
        check("t6_exec", {31'd0, bus.uop_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_uop_valid", {31'd0, bus.uop_valid}, 0);
        check("t6_rst_busy", {31'd0, bus.busy}, 0);
        check("t6_rst_uop_addr", {25'd0, bus.uop_addr}, 0);
        check("t6_rst_retired", bus.retired_cnt, 0);
        check("t6_rst_trap_valid", {31'd0, bus.trap_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        r_model = 0;
        rom[9'h001] = 7'd1;
        bus.op_code = 8'h01; bus.op_valid = 1; bus.uop_ready = 1; bus.uop_last = 1;
        n = 0;
        while (bus.retired_cnt != CW'((1 << CW) - 1) && n < 2000) begin tick(); n++; end
        bus.op_valid = 0;
        check("t6_cnt_max", bus.retired_cnt, (1 << CW) - 1);
        check("t6_idle_at_max", {31'd0, bus.busy}, 0);
        issue_op(8'h01);
        tick();
        tick();
        bus.uop_ready = 0; bus.uop_last = 0;
        check("t6_wrap", bus.retired_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
